// File: rtl/cp0_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cp0_regfile: MIPS CP0 registers, Count/Compare timer, exception responder |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cp0_regfile #(
  parameter int IRQ_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [4:0]       waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [4:0]       raddr_i,
  output logic [31:0]      rdata_o,
  input  logic [IRQ_W-1:0] int_i,
  input  logic             exc_valid_i,
  input  logic [4:0]       exc_code_i,
  input  logic [31:0]      exc_pc_i,
  input  logic             exc_bd_i,
  input  logic [31:0]      exc_badaddr_i,
  input  logic             eret_i,
  output logic [31:0]      status_o,
  output logic [31:0]      cause_o,
  output logic [31:0]      epc_o,
  output logic             timer_int_o,
  output logic             int_pending_o
);

  localparam logic [4:0]  c_ADDR_BADVADDR = 5'd8;
  localparam logic [4:0]  c_ADDR_COUNT    = 5'd9;
  localparam logic [4:0]  c_ADDR_COMPARE  = 5'd11;
  localparam logic [4:0]  c_ADDR_STATUS   = 5'd12;
  localparam logic [4:0]  c_ADDR_CAUSE    = 5'd13;
  localparam logic [4:0]  c_ADDR_EPC      = 5'd14;
  localparam logic [4:0]  c_EXC_ADEL      = 5'h04;
  localparam logic [4:0]  c_EXC_ADES      = 5'h05;
  localparam logic [31:0] c_STATUS_RESET  = 32'h0040_0000;
  // IM[15:8], EXL[1], IE[0]
  localparam logic [31:0] c_STATUS_WMASK  = 32'h0000_FF03;

  logic [31:0] r_badvaddr;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [31:0] r_status;
  logic [31:0] r_cause;
  logic [31:0] r_epc;
  logic        r_phase;
  logic        r_timer_int;
  logic [5:0]  w_irq;

  assign w_irq = 6'(int_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_badvaddr  <= 32'd0;
      r_count     <= 32'd0;
      r_compare   <= 32'd0;
      r_status    <= c_STATUS_RESET;
      r_cause     <= 32'd0;
      r_epc       <= 32'd0;
      r_phase     <= 1'b0;
      r_timer_int <= 1'b0;
    end else begin
      // Hardware activity first; the software write below overrides where it collides.
      r_phase <= ~r_phase;
      if (r_phase) begin
        r_count <= r_count + 32'd1;
      end
      if ((r_count == r_compare) && (r_compare != 32'd0)) begin
        r_timer_int <= 1'b1;
      end
      r_cause[15:10] <= {w_irq[5] | r_timer_int, w_irq[4:0]};

      if (exc_valid_i) begin
        if (!r_status[1]) begin
          r_epc       <= exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
          r_cause[31] <= exc_bd_i;
        end
        r_status[1]  <= 1'b1;
        r_cause[6:2] <= exc_code_i;
        if ((exc_code_i == c_EXC_ADEL) || (exc_code_i == c_EXC_ADES)) begin
          r_badvaddr <= exc_badaddr_i;
        end
      end else if (eret_i) begin
        r_status[1] <= 1'b0;
      end else if (we_i) begin
        case (waddr_i)
          c_ADDR_COUNT: begin
            r_count <= wdata_i;
            r_phase <= 1'b0;
          end
          c_ADDR_COMPARE: begin
            r_compare   <= wdata_i;
            r_timer_int <= 1'b0;
          end
          c_ADDR_STATUS: r_status    <= (r_status & ~c_STATUS_WMASK) | (wdata_i & c_STATUS_WMASK);
          c_ADDR_CAUSE:  r_cause[9:8] <= wdata_i[9:8];
          c_ADDR_EPC:    r_epc       <= wdata_i;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata_o = 32'd0;
    case (raddr_i)
      c_ADDR_BADVADDR: rdata_o = r_badvaddr;
      c_ADDR_COUNT:    rdata_o = r_count;
      c_ADDR_COMPARE:  rdata_o = r_compare;
      c_ADDR_STATUS:   rdata_o = r_status;
      c_ADDR_CAUSE:    rdata_o = r_cause;
      c_ADDR_EPC:      rdata_o = r_epc;
      default:         rdata_o = 32'd0;
    endcase
  end

  assign status_o      = r_status;
  assign cause_o       = r_cause;
  assign epc_o         = r_epc;
  assign timer_int_o   = r_timer_int;
  assign int_pending_o = r_status[0] & ~r_status[1] & (|(r_cause[15:8] & r_status[15:8]));

endmodule
`default_nettype wire
